// File: rtl/gnrc_slot_alloc.sv
// gnrc_slot_alloc: registered bitmap slot allocator.
// A used/free bitmap is searched for the lowest free slot. That slot is
// pre-loaded into an output register, marked used at the same time, and
// offered on a valid/ready handshake. A released slot re-enters the pool
// on the following cycle, because the search only ever reads the
// registered bitmap.

// gnrc_lzc_bin: binary zero counter with an empty flag.
// MODE = 0 counts trailing zeros, which gives the index of the lowest set
// bit. MODE = 1 counts leading zeros. When the input is all zero, cnt_o
// reads 0 and empty_o is raised.
module gnrc_lzc_bin #(
  parameter int unsigned WIDTH = 8,
  parameter bit          MODE  = 1'b0,
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             empty_o
);

  // Priority scan. The last matching bit seen wins, so the loop direction
  // selects either the lowest or the highest set bit.
  always_comb begin
    cnt_o   = '0;
    empty_o = (in_i == '0);
    if (MODE == 1'b0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (in_i[i]) begin
          cnt_o = CNT_W'(i);
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_i[i]) begin
          cnt_o = CNT_W'(WIDTH - 1 - i);
        end
      end
    end
  end

endmodule

module gnrc_slot_alloc #(
  parameter int unsigned NUM_SLOTS = 16,
  localparam int unsigned IDX_WIDTH = $clog2(NUM_SLOTS),
  localparam int unsigned CNT_WIDTH = $clog2(NUM_SLOTS + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 alloc_valid_o,
  input  logic                 alloc_ready_i,
  output logic [IDX_WIDTH-1:0] alloc_idx_o,
  input  logic                 free_valid_i,
  input  logic [IDX_WIDTH-1:0] free_idx_i,
  output logic [CNT_WIDTH-1:0] used_cnt_o,
  output logic                 full_o,
  output logic                 err_o
);

  localparam int unsigned EXT_SLOTS = 1 << IDX_WIDTH;
  localparam logic [NUM_SLOTS-1:0] ONE_HOT0 = NUM_SLOTS'(1);

  logic [NUM_SLOTS-1:0] used_q, used_d;
  logic                 out_valid_q, out_valid_d;
  logic [IDX_WIDTH-1:0] out_idx_q, out_idx_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic [IDX_WIDTH-1:0] search_idx;
  logic                 none;
  logic                 handshake;
  logic                 load;
  logic [EXT_SLOTS-1:0] used_ext;
  logic                 idx_in_range;
  logic                 rel_legal;
  logic                 rel_ok;
  logic [NUM_SLOTS-1:0] load_mask;
  logic [NUM_SLOTS-1:0] rel_mask;

  // Lowest free slot, looking only at the registered bitmap.
  gnrc_lzc_bin #(
    .WIDTH (NUM_SLOTS),
    .MODE  (1'b0)
  ) u_search (
    .in_i    (~used_q),
    .cnt_o   (search_idx),
    .empty_o (none)
  );

  // The bitmap is zero-padded up to a power of two. This lets an
  // out-of-range release index be looked up safely; it reads as free.
  always_comb begin
    used_ext                = '0;
    used_ext[NUM_SLOTS-1:0] = used_q;
  end

  // Handshake, load and release qualification. The pre-loaded slot is
  // already marked used, but the consumer does not own it yet, so it
  // cannot be released.
  always_comb begin
    handshake    = out_valid_q && alloc_ready_i;
    load         = (!out_valid_q || handshake) && !none;
    idx_in_range = ({1'b0, free_idx_i} < (IDX_WIDTH + 1)'(NUM_SLOTS));
    rel_legal    = idx_in_range && used_ext[free_idx_i] &&
                   !(out_valid_q && (free_idx_i == out_idx_q));
    rel_ok       = free_valid_i && rel_legal;
  end

  // Next-state computation. A load always targets a free bit and a release
  // always targets a used bit, so the two masks never overlap. The counter
  // can therefore add the load and subtract the release independently.
  always_comb begin
    load_mask   = load   ? (ONE_HOT0 << search_idx) : '0;
    rel_mask    = rel_ok ? (ONE_HOT0 << free_idx_i) : '0;
    used_d      = (used_q | load_mask) & ~rel_mask;
    cnt_d       = cnt_q + CNT_WIDTH'(load) - CNT_WIDTH'(rel_ok);
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_idx_d   = search_idx;
    end else if (handshake) begin
      out_valid_d = 1'b0;
    end
    err_d = free_valid_i && !rel_legal;
  end

  // State registers. Reset is asynchronous and clears everything,
  // including any offer in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      used_q      <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      used_q      <= used_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  assign alloc_valid_o = out_valid_q;
  assign alloc_idx_o   = out_idx_q;
  assign used_cnt_o    = cnt_q;
  assign full_o        = (cnt_q == CNT_WIDTH'(NUM_SLOTS));
  assign err_o         = err_q;

endmodule

// File: tb/tb_gnrc_slot_alloc.sv
// Testbench for gnrc_slot_alloc.
// Three instances are built: one with 4 slots, one with 5 and one with 8.
// A table of per-cycle vectors selects an instance and drives its inputs
// on the falling edge. Each vector's expected outputs go into a
// scoreboard queue, and are popped and compared just after the next
// rising edge.
module tb_gnrc_slot_alloc;

  typedef struct {
    logic [1:0] sel;
    logic       rst;
    logic       rdy;
    logic       fv;
    logic [3:0] fidx;
    logic       ev;
    logic [3:0] eidx;
    logic [3:0] ecnt;
    logic       efull;
    logic       eerr;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [1:0] sel;
  logic       rdy;
  logic       fv;
  logic [3:0] fidx;

  logic       valid4, full4, err4;
  logic [1:0] idx4;
  logic [2:0] cnt4;
  logic       valid5, full5, err5;
  logic [2:0] idx5;
  logic [2:0] cnt5;
  logic       valid8, full8, err8;
  logic [2:0] idx8;
  logic [3:0] cnt8;

  logic       obsValid, obsFull, obsErr;
  logic [3:0] obsIdx, obsCnt;
  int         popUsed;

  vec_t  vecs[$];
  vec_t  expQ[$];
  int    checks;
  int    errors;
  string curTag;

  gnrc_slot_alloc #(.NUM_SLOTS(4)) u4 (
    .clk_i         (clk),
    .rst_i         (rst),
    .alloc_valid_o (valid4),
    .alloc_ready_i (rdy && (sel == 2'd0)),
    .alloc_idx_o   (idx4),
    .free_valid_i  (fv && (sel == 2'd0)),
    .free_idx_i    (fidx[1:0]),
    .used_cnt_o    (cnt4),
    .full_o        (full4),
    .err_o         (err4)
  );

  gnrc_slot_alloc #(.NUM_SLOTS(5)) u5 (
    .clk_i         (clk),
    .rst_i         (rst),
    .alloc_valid_o (valid5),
    .alloc_ready_i (rdy && (sel == 2'd1)),
    .alloc_idx_o   (idx5),
    .free_valid_i  (fv && (sel == 2'd1)),
    .free_idx_i    (fidx[2:0]),
    .used_cnt_o    (cnt5),
    .full_o        (full5),
    .err_o         (err5)
  );

  gnrc_slot_alloc #(.NUM_SLOTS(8)) u8 (
    .clk_i         (clk),
    .rst_i         (rst),
    .alloc_valid_o (valid8),
    .alloc_ready_i (rdy && (sel == 2'd2)),
    .alloc_idx_o   (idx8),
    .free_valid_i  (fv && (sel == 2'd2)),
    .free_idx_i    (fidx[2:0]),
    .used_cnt_o    (cnt8),
    .full_o        (full8),
    .err_o         (err8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Route the selected instance onto one common set of observation signals.
  always_comb begin
    obsValid = valid4;
    obsIdx   = 4'(idx4);
    obsCnt   = 4'(cnt4);
    obsFull  = full4;
    obsErr   = err4;
    popUsed  = $countones(u4.used_q);
    case (sel)
      2'd1: begin
        obsValid = valid5;
        obsIdx   = 4'(idx5);
        obsCnt   = 4'(cnt5);
        obsFull  = full5;
        obsErr   = err5;
        popUsed  = $countones(u5.used_q);
      end
      2'd2: begin
        obsValid = valid8;
        obsIdx   = 4'(idx8);
        obsCnt   = 4'(cnt8);
        obsFull  = full8;
        obsErr   = err8;
        popUsed  = $countones(u8.used_q);
      end
      default: ;
    endcase
  end

  // Safety net: if the run ever stalls, report a failure and stop.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  function automatic vec_t mk(int s, int r, int rd, int f, int fi,
                              int v, int i, int c, int fu, int e);
    vec_t x;
    x.sel   = 2'(s);
    x.rst   = 1'(r);
    x.rdy   = 1'(rd);
    x.fv    = 1'(f);
    x.fidx  = 4'(fi);
    x.ev    = 1'(v);
    x.eidx  = 4'(i);
    x.ecnt  = 4'(c);
    x.efull = 1'(fu);
    x.eerr  = 1'(e);
    return x;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s %s: actual=%0d required=%0d", curTag, name, act, exp);
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard: actual=empty required=entry", curTag);
      return;
    end
    e = expQ.pop_front();
    cmp("alloc_valid", int'(obsValid), int'(e.ev));
    cmp("alloc_idx",   int'(obsIdx),   int'(e.eidx));
    cmp("used_cnt",    int'(obsCnt),   int'(e.ecnt));
    cmp("full",        int'(obsFull),  int'(e.efull));
    cmp("err",         int'(obsErr),   int'(e.eerr));
    cmp("cnt_vs_popcount", popUsed, int'(e.ecnt));
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    sel  = v.sel;
    rst  = v.rst;
    rdy  = v.rdy;
    fv   = v.fv;
    fidx = v.fidx;
    expQ.push_back(v);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    rst    = 1'b1;
    sel    = 2'd0;
    rdy    = 1'b0;
    fv     = 1'b0;
    fidx   = 4'd0;
    checks = 0;
    errors = 0;
    curTag = "init";

    // Fields: sel rst rdy fv fidx | valid idx cnt full err
    // 4 slots: drain the pool, then release slot 2 and watch it come back.
    vecs.push_back(mk(0,1,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,0, 1,0,1,0,0));
    vecs.push_back(mk(0,0,1,0,0, 1,1,2,0,0));
    vecs.push_back(mk(0,0,1,0,0, 1,2,3,0,0));
    vecs.push_back(mk(0,0,1,0,0, 1,3,4,1,0));
    vecs.push_back(mk(0,0,1,0,0, 0,3,4,1,0));
    vecs.push_back(mk(0,0,1,1,2, 0,3,3,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,2,4,1,0));
    vecs.push_back(mk(0,0,0,0,0, 1,2,4,1,0));
    // 4 slots: slot 0 is presented and stalled while 1, 2 and 3 are released;
    // then come the illegal releases.
    vecs.push_back(mk(0,1,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,0, 1,0,1,0,0));
    vecs.push_back(mk(0,0,1,0,0, 1,1,2,0,0));
    vecs.push_back(mk(0,0,1,0,0, 1,2,3,0,0));
    vecs.push_back(mk(0,0,1,0,0, 1,3,4,1,0));
    vecs.push_back(mk(0,0,1,0,0, 0,3,4,1,0));
    vecs.push_back(mk(0,0,0,1,0, 0,3,3,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,0,4,1,0));
    vecs.push_back(mk(0,0,0,0,0, 1,0,4,1,0));
    vecs.push_back(mk(0,0,0,0,0, 1,0,4,1,0));
    vecs.push_back(mk(0,0,0,0,0, 1,0,4,1,0));
    vecs.push_back(mk(0,0,0,0,0, 1,0,4,1,0));
    vecs.push_back(mk(0,0,0,1,1, 1,0,3,0,0));
    vecs.push_back(mk(0,0,0,1,2, 1,0,2,0,0));
    vecs.push_back(mk(0,0,0,1,3, 1,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,0,1,0,0));
    vecs.push_back(mk(0,0,0,1,0, 1,0,1,0,1));
    vecs.push_back(mk(0,0,0,0,0, 1,0,1,0,0));
    vecs.push_back(mk(0,0,0,1,2, 1,0,1,0,1));
    vecs.push_back(mk(0,0,0,0,0, 1,0,1,0,0));
    vecs.push_back(mk(0,0,1,0,0, 1,1,2,0,0));
    // 5 slots: release indices beyond the pool.
    vecs.push_back(mk(1,1,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0, 1,0,1,0,0));
    vecs.push_back(mk(1,0,0,1,5, 1,0,1,0,1));
    vecs.push_back(mk(1,0,0,0,0, 1,0,1,0,0));
    vecs.push_back(mk(1,0,0,1,7, 1,0,1,0,1));
    vecs.push_back(mk(1,0,0,0,0, 1,0,1,0,0));
    vecs.push_back(mk(1,0,1,0,0, 1,1,2,0,0));
    // 8 slots: handshake of 1 in the same cycle as release of 0.
    vecs.push_back(mk(2,1,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(2,0,1,0,0, 1,0,1,0,0));
    vecs.push_back(mk(2,0,1,0,0, 1,1,2,0,0));
    vecs.push_back(mk(2,0,1,0,0, 1,2,3,0,0));
    vecs.push_back(mk(2,0,1,0,0, 1,3,4,0,0));
    vecs.push_back(mk(2,0,0,1,1, 1,3,3,0,0));
    vecs.push_back(mk(2,0,1,0,0, 1,1,4,0,0));
    vecs.push_back(mk(2,0,1,1,0, 1,4,4,0,0));
    vecs.push_back(mk(2,0,1,0,0, 1,0,5,0,0));

    $display("[TB] running %0d table vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      curTag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i]);
    end

    // Hand-written sequence: asynchronous reset with 3 slots allocated.
    curTag = "async_setup";
    applyStimulus(mk(0,1,0,0,0, 0,0,0,0,0));
    applyStimulus(mk(0,0,1,0,0, 1,0,1,0,0));
    applyStimulus(mk(0,0,1,0,0, 1,1,2,0,0));
    applyStimulus(mk(0,0,1,0,0, 1,2,3,0,0));
    curTag = "async_reset";
    #2;
    rst = 1'b1;
    rdy = 1'b0;
    #1;
    expQ.push_back(mk(0,1,0,0,0, 0,0,0,0,0));
    checkOutput();
    curTag = "after_async_reset";
    applyStimulus(mk(0,0,1,0,0, 1,0,1,0,0));
    applyStimulus(mk(0,0,1,0,0, 1,1,2,0,0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
